axi_stream_packet_source: RTL
=============================

# axi_stream_packet_source

Packet-aware AXI4-Stream transmitter: accepts beats on a simple valid/ready push port, buffers them in an internal FIFO, and drives them out as a protocol-compliant AXI4-Stream master. It is the driving end for any downstream AXI4-Stream receiver in the infrastructure. An optional store-and-forward mode holds TVALID until a complete packet (TLAST) is buffered. It is therefore safe to place in front of the slave-side property set without violating any handshake, stability or reset rule.

## Interface
- byte_width, 4, bytes per beat; TDATA is 8*byte_width bits
- user_width, 1, TUSER width (minimum 1)
- depth_log2, 3, FIFO depth = 2**depth_log2 beats (minimum 1)
- PACKET_MODE, 1'b0, 1 = store-and-forward, 0 = cut-through
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  push beat offered
- in_ready  out  1  push beat accepted when in_valid && in_ready
- in_data  in  8*byte_width  beat data
- in_keep  in  byte_width  byte-keep mask
- in_last  in  1  final beat of packet
- in_user  in  user_width  sideband
- tvalid  out  1  AXI4-Stream TVALID
- tready  in  1  AXI4-Stream TREADY
- tdata  out  8*byte_width  TDATA
- tkeep  out  byte_width  TKEEP
- tstrb  out  byte_width  TSTRB, always equal to tkeep (no position bytes generated)
- tlast  out  1  TLAST
- tuser  out  user_width  TUSER
- level  out  depth_log2+1  beats currently buffered
- pkt_count  out  16  count of TLAST handshakes, wraps 0xFFFF -> 0

## Operation
- Storage: circular buffer, write pointer, read pointer, occupancy `level` (0..DEPTH).
- Push: on in_valid && in_ready, store {data, keep, last, user} at write pointer. in_ready = resetn && (level != DEPTH). No bypass when full, even if a pop occurs in the same cycle.
- Pop: on tvalid && tready, advance read pointer. Outputs tdata/tkeep/tlast/tuser come from the read-pointer entry.
- Simultaneous push and pop: level unchanged. Both pointers wrap modulo DEPTH.
- complete counter (depth_log2+1 bits):
  - +1 on a push with in_last;
  - -1 on a pop with tlast;
  - both in the same cycle: unchanged.
- mid_packet flag:
  - set on a pop with !tlast;
  - cleared on a pop with tlast.
- tvalid is:
  - PACKET_MODE=0: level != 0.
  - PACKET_MODE=1: level != 0 && (complete != 0 || level == DEPTH || mid_packet). The full-buffer term is the oversize-packet fallback: a packet longer than DEPTH streams out cut-through. mid_packet keeps that packet flowing to its TLAST.
- TVALID never falls except on a handshake or reset. Every term above can only decrease through a pop.
- Payload outputs are stable while tvalid && !tready.
- pkt_count increments on each pop with tlast.
- Beats with in_keep == 0 (null beats) are stored and forwarded unchanged.

## Timing
- Reset (resetn low, asynchronous):
  - level, pointers, complete, mid_packet and pkt_count are forced to 0;
  - tvalid = 0 and in_ready = 0 immediately;
  - buffer contents are not reset, and tdata/tkeep/tlast/tuser are don't-care while tvalid = 0.
- Release: on the first rising clk edge with resetn high. in_ready = 1 from that point.
- Reset mid-packet: all buffered beats, including partial packets, are discarded, and tvalid drops within reset. This is legal because the downstream receiver is also in reset.
- Latency, cut-through: a beat pushed at edge N presents tvalid in the cycle after edge N (1 cycle).
- Latency, store-and-forward: tvalid rises in the cycle after the edge that pushes the TLAST beat. In the oversize fallback, it rises in the cycle after the edge at which level reaches DEPTH.
- Throughput: 1 beat/cycle sustained when tready = 1 and level is between 1 and DEPTH-1.
- in_ready, tvalid and level are combinational only from registers. There is no combinational path from tready to in_ready or from in_valid to tvalid.

## Test plan
- Reset then single beat, PACKET_MODE=0:
  - stimulus: push data=0xDEADBEEF, keep=0xF, last=1 at edge 1, with tready=1;
  - required: tvalid=1 in the cycle after edge 1, tdata=0xDEADBEEF, tstrb=0xF, tlast=1;
  - required: pkt_count=1 after the handshake, level back to 0.
- Backpressure stability:
  - stimulus: push 3 beats, then hold tready=0 for 5 cycles;
  - required: tvalid stays 1 and tdata/tkeep/tlast/tuser stay unchanged;
  - required: after tready=1, the beats arrive in order in 3 consecutive cycles.
- Full, depth 8:
  - stimulus: push 8 beats with tready=0;
  - required: in_ready=0 with level=8;
  - stimulus: then pop 1 beat while in_valid=1;
  - required: no push in the pop cycle, in_ready=1 on the next cycle.
- Store-and-forward, PACKET_MODE=1:
  - stimulus: push 4 beats, last on beat 4, one per cycle;
  - required: tvalid stays 0 until the cycle after beat 4 is pushed;
  - required: 4 beats out back-to-back, tlast only on beat 4.
- Oversize packet, PACKET_MODE=1, depth 8:
  - stimulus: push a 12-beat packet with tready=1;
  - required: tvalid rises when level reaches 8 and never falls until the beat-12 TLAST handshake;
  - required: all 12 beats delivered, pkt_count=1.
- Reset mid-transfer:
  - stimulus: assert resetn=0 asynchronously with 5 beats buffered and tvalid=1;
  - required: tvalid=0 and in_ready=0 immediately, level=0, pkt_count=0;
  - required: after release, the next pushed packet is delivered with no stale beats.

Source files
------------

// File: rtl/axi_stream_packet_source.sv
// axi_stream_packet_source
//   Packet-aware AXI4-Stream master. Beats enter on a simple valid/ready push
//   port, are buffered in a circular FIFO of 2**depth_log2 entries and leave
//   as an AXI4-Stream. With PACKET_MODE=1 the stream is held back until a
//   whole packet (TLAST) is buffered, except when a packet is too long to fit,
//   in which case it streams out cut-through once the buffer fills.
//
// Ports
//   clk, resetn          clock, asynchronous active-low reset
//   in_valid/in_ready    push handshake
//   in_data/keep/last/user  pushed beat
//   tvalid/tready        AXI4-Stream handshake
//   tdata/tkeep/tstrb/tlast/tuser  AXI4-Stream payload (tstrb mirrors tkeep)
//   level                beats currently buffered (0..DEPTH)
//   pkt_count            TLAST handshakes, 16-bit wrapping
module axi_stream_packet_source #(
  parameter int   byte_width  = 4,
  parameter int   user_width  = 1,
  parameter int   depth_log2  = 3,
  parameter logic PACKET_MODE = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*byte_width-1:0] in_data,
  input  logic [byte_width-1:0]   in_keep,
  input  logic                    in_last,
  input  logic [user_width-1:0]   in_user,
  output logic                    tvalid,
  input  logic                    tready,
  output logic [8*byte_width-1:0] tdata,
  output logic [byte_width-1:0]   tkeep,
  output logic [byte_width-1:0]   tstrb,
  output logic                    tlast,
  output logic [user_width-1:0]   tuser,
  output logic [depth_log2:0]     level,
  output logic [15:0]             pkt_count
);

  localparam int DW      = 8 * byte_width;
  localparam int EW      = DW + byte_width + 1 + user_width;
  localparam int DEPTH_I = 1 << depth_log2;
  localparam logic [depth_log2:0]   DEPTH   = DEPTH_I[depth_log2:0];
  localparam logic [depth_log2:0]   LVL_ONE = 1;
  localparam logic [depth_log2-1:0] PTR_ONE = 1;
  localparam logic [15:0]           CNT_ONE = 16'd1;

  // Storage carries no reset: contents are only observable through the read
  // pointer while level != 0, and level is forced to 0 by reset.
  logic [EW-1:0] mem [DEPTH_I];

  logic [depth_log2-1:0] wr_ptr, rd_ptr;
  logic [depth_log2:0]   complete;   // whole packets (TLAST beats) buffered
  logic                  mid_packet; // a packet has started leaving but not ended
  logic                  full, push, pop;
  logic                  last_in, last_out;

  assign full     = (level == DEPTH);
  // resetn gates in_ready directly so it drops the instant reset asserts.
  // A full buffer refuses pushes even when a pop is happening this cycle;
  // this keeps in_ready free of any path from tready.
  assign in_ready = resetn & ~full;
  assign push     = in_valid & in_ready;
  assign pop      = tvalid & tready;
  assign last_in  = push & in_last;
  assign last_out = pop & tlast;

  // Outputs come straight from the head entry, so they cannot change until
  // rd_ptr advances on a handshake.
  assign {tdata, tkeep, tlast, tuser} = mem[rd_ptr];
  assign tstrb = tkeep;

  // Every term of tvalid only shrinks on a pop, so TVALID cannot retract
  // without a handshake. The full term lets an oversize packet escape; once
  // it has started, mid_packet keeps it flowing until its TLAST.
  generate
    if (PACKET_MODE) begin : g_store_fwd
      assign tvalid = (level != '0) && ((complete != '0) || full || mid_packet);
    end else begin : g_cut_through
      assign tvalid = (level != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_data, in_keep, in_last, in_user};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      complete <= '0;
    end else begin
      case ({last_in, last_out})
        2'b10:   complete <= complete + LVL_ONE;
        2'b01:   complete <= complete - LVL_ONE;
        default: complete <= complete;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mid_packet <= 1'b0;
      pkt_count  <= '0;
    end else begin
      if (pop)      mid_packet <= ~tlast;
      if (last_out) pkt_count  <= pkt_count + CNT_ONE;
    end
  end

endmodule
